// File: rtl/clint_ctrl.sv
// rtl/clint_ctrl.sv - core-local trap/interrupt controller sequencing CSR writes and pipeline redirects
// Optional macro: CLINT_VECTORED_EN (vectored async trap targets when mtvec[1:0] == 2'b01)
module clint_ctrl #(
    parameter int INT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_flag_i,
    input  logic             global_int_en_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      raddr_o,
    output logic [31:0]      data_o,
    output logic             hold_flag_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
    localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

    // Trap and MRET sequences share one state register; both start and end in S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MSTATUS,
        S_W_MCAUSE,
        S_ASSERT,
        S_M_MSTATUS,
        S_M_ASSERT
    } state_t;

    state_t state;
    state_t state_next;

    logic        is_ecall;
    logic        is_ebreak;
    logic        is_mret;
    logic        sync_det;
    logic        async_det;
    logic        mret_det;
    logic [31:0] mepc_det;
    logic [31:0] mcause_det;
    logic [31:0] mcause_q;
    logic [31:0] mstatus_trap;
    logic [31:0] mstatus_mret;
    logic [31:0] trap_target;

    logic        we_d;
    logic [31:0] waddr_d;
    logic [31:0] data_d;
    logic        int_assert_d;
    logic [31:0] int_addr_d;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);

    // Detection happens only while idle; sync beats async beats MRET.
    assign sync_det  = (state == S_IDLE) && (is_ecall || is_ebreak);
    assign async_det = (state == S_IDLE) && !sync_det && global_int_en_i
                       && (|int_flag_i) && !hold_flag_i;
    assign mret_det  = (state == S_IDLE) && !sync_det && !async_det && is_mret;

    assign mepc_det   = sync_det ? inst_addr_i : (jump_flag_i ? jump_addr_i : inst_addr_i);
    assign mcause_det = sync_det ? (is_ecall ? CAUSE_ECALL : CAUSE_EBREAK)
                                 : (int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT);

    // Trap entry: MPIE <- MIE, MIE <- 0. Return: MIE <- MPIE, MPIE <- 1.
    assign mstatus_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                           1'b0, csr_mstatus_i[2:0]};
    assign mstatus_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                           csr_mstatus_i[7], csr_mstatus_i[2:0]};

    assign hold_flag_o = (state != S_IDLE) || sync_det || async_det || mret_det;
    assign raddr_o     = 32'h0;

`ifdef CLINT_VECTORED_EN
    logic async_q;

    // Remember whether the latched trap was asynchronous, for vector selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            async_q <= 1'b0;
        end else if (sync_det || async_det) begin
            async_q <= async_det;
        end
    end

    // Vectored mode offsets async traps by 4*cause; sync traps use the base.
    always_comb begin
        trap_target = {csr_mtvec_i[31:2], 2'b00};
        if (async_q && (csr_mtvec_i[1:0] == 2'b01)) begin
            trap_target = trap_target + {25'd0, mcause_q[4:0], 2'b00};
        end
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_i[1:0];

    // Direct mode only: mode bits of mtvec are ignored.
    always_comb begin
        trap_target = {csr_mtvec_i[31:2], 2'b00};
    end
`endif

    // Latch the trap cause at detection; mepc is written on the very next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcause_q <= 32'h0;
        end else if (sync_det || async_det) begin
            mcause_q <= mcause_det;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed sequences once a trap or MRET is accepted.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (sync_det || async_det) begin
                    state_next = S_W_MEPC;
                end else if (mret_det) begin
                    state_next = S_M_MSTATUS;
                end
            end
            S_W_MEPC:    state_next = S_W_MSTATUS;
            S_W_MSTATUS: state_next = S_W_MCAUSE;
            S_W_MCAUSE:  state_next = S_ASSERT;
            S_ASSERT:    state_next = S_IDLE;
            S_M_MSTATUS: state_next = S_M_ASSERT;
            S_M_ASSERT:  state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Output decode for the state being entered; registered below.
    always_comb begin
        we_d         = 1'b0;
        waddr_d      = 32'h0;
        data_d       = 32'h0;
        int_assert_d = 1'b0;
        int_addr_d   = int_addr_o;
        case (state_next)
            S_W_MEPC: begin
                we_d    = 1'b1;
                waddr_d = CSR_MEPC;
                data_d  = mepc_det;
            end
            S_W_MSTATUS: begin
                we_d    = 1'b1;
                waddr_d = CSR_MSTATUS;
                data_d  = mstatus_trap;
            end
            S_W_MCAUSE: begin
                we_d    = 1'b1;
                waddr_d = CSR_MCAUSE;
                data_d  = mcause_q;
            end
            S_ASSERT: begin
                int_assert_d = 1'b1;
                int_addr_d   = trap_target;
            end
            S_M_MSTATUS: begin
                we_d    = 1'b1;
                waddr_d = CSR_MSTATUS;
                data_d  = mstatus_mret;
            end
            S_M_ASSERT: begin
                int_assert_d = 1'b1;
                int_addr_d   = csr_mepc_i;
            end
            default: ;
        endcase
    end

    // Registered CSR port and redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_o         <= 1'b0;
            waddr_o      <= 32'h0;
            data_o       <= 32'h0;
            int_assert_o <= 1'b0;
            int_addr_o   <= 32'h0;
        end else begin
            we_o         <= we_d;
            waddr_o      <= waddr_d;
            data_o       <= data_d;
            int_assert_o <= int_assert_d;
            int_addr_o   <= int_addr_d;
        end
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// tb/tb_clint_ctrl.sv - scoreboard bench for clint_ctrl
module tb_clint_ctrl;

    localparam int INT_W = 8;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
`ifdef CLINT_VECTORED_EN
    localparam logic [31:0] TIMER_VEC = 32'h0000_011C;
`else
    localparam logic [31:0] TIMER_VEC = 32'h0000_0100;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [INT_W-1:0] int_flag_i;
    logic [31:0]      inst_i;
    logic [31:0]      inst_addr_i;
    logic             jump_flag_i;
    logic [31:0]      jump_addr_i;
    logic             hold_flag_i;
    logic             global_int_en_i;
    logic [31:0]      csr_mtvec_i;
    logic [31:0]      csr_mepc_i;
    logic [31:0]      csr_mstatus_i;
    logic             we_o;
    logic [31:0]      waddr_o;
    logic [31:0]      raddr_o;
    logic [31:0]      data_o;
    logic             hold_flag_o;
    logic             int_assert_o;
    logic [31:0]      int_addr_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0] wq[$];
    logic [31:0] rq[$];

    clint_ctrl #(.INT_W(INT_W)) dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .global_int_en_i(global_int_en_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .we_o(we_o), .waddr_o(waddr_o), .raddr_o(raddr_o), .data_o(data_o),
        .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every CSR write and every redirect strobe must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (we_o) begin
                total_cnt++;
                if (wq.size() == 0) begin
                    $display("FAIL csr_write unexpected: got addr=%h data=%h, required none", waddr_o, data_o);
                end else begin
                    logic [63:0] exp_w;
                    exp_w = wq.pop_front();
                    if ({waddr_o, data_o} !== exp_w)
                        $display("FAIL csr_write: got addr=%h data=%h, required addr=%h data=%h",
                                 waddr_o, data_o, exp_w[63:32], exp_w[31:0]);
                    else
                        pass_cnt++;
                end
            end
            if (int_assert_o) begin
                total_cnt++;
                if (rq.size() == 0) begin
                    $display("FAIL redirect unexpected: got addr=%h, required none", int_addr_o);
                end else begin
                    logic [31:0] exp_r;
                    exp_r = rq.pop_front();
                    if (int_addr_o !== exp_r)
                        $display("FAIL redirect: got addr=%h, required %h", int_addr_o, exp_r);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        int_flag_i = '0; inst_i = NOP; inst_addr_i = 32'h0; jump_flag_i = 1'b0;
        jump_addr_i = 32'h0; hold_flag_i = 1'b0; global_int_en_i = 1'b0;
        csr_mtvec_i = 32'h100; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h0;
        step(); step();
        total_cnt++;
        if ({we_o, waddr_o, data_o, int_assert_o, int_addr_o, hold_flag_o, raddr_o} !== '0)
            $display("FAIL reset_state: got we=%b waddr=%h data=%h assert=%b addr=%h hold=%b raddr=%h, required all 0",
                     we_o, waddr_o, data_o, int_assert_o, int_addr_o, hold_flag_o, raddr_o);
        else
            pass_cnt++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_ecall();
        csr_mtvec_i = 32'h100; csr_mstatus_i = 32'h8; inst_addr_i = 32'h80; inst_i = ECALL;
        wq.push_back({32'h341, 32'h80});
        wq.push_back({32'h300, 32'h80});
        wq.push_back({32'h342, 32'hB});
        rq.push_back(32'h100);
        for (int c = 0; c < 6; c++) begin
            logic exp_hold;
            exp_hold = (c <= 4);
            @(negedge clk);
            total_cnt++;
            if (hold_flag_o !== exp_hold)
                $display("FAIL ecall_hold c%0d: got %b, required %b", c, hold_flag_o, exp_hold);
            else
                pass_cnt++;
            total_cnt++;
            if (int_assert_o !== (c == 4))
                $display("FAIL ecall_strobe c%0d: got %b, required %b", c, int_assert_o, (c == 4));
            else
                pass_cnt++;
            step();
            if (c == 0) inst_i = NOP;
        end
        total_cnt++;
        if (wq.size() != 0 || rq.size() != 0)
            $display("FAIL ecall_drain: got %0d writes %0d redirects left, required 0", wq.size(), rq.size());
        else
            pass_cnt++;
    endtask

    task automatic test_timer();
        csr_mstatus_i = 32'h8; inst_addr_i = 32'h90; inst_i = NOP;
        int_flag_i = 8'h01; global_int_en_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        wq.push_back({32'h341, 32'h200});
        wq.push_back({32'h300, 32'h80});
        wq.push_back({32'h342, 32'h8000_0007});
        rq.push_back(32'h100);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total_cnt++;
            if (hold_flag_o !== (c <= 4))
                $display("FAIL timer_hold c%0d: got %b, required %b", c, hold_flag_o, (c <= 4));
            else
                pass_cnt++;
            step();
            if (c == 0) begin
                int_flag_i = '0; jump_flag_i = 1'b0; global_int_en_i = 1'b0;
            end
        end
        total_cnt++;
        if (wq.size() != 0 || rq.size() != 0)
            $display("FAIL timer_drain: got %0d writes %0d redirects left, required 0", wq.size(), rq.size());
        else
            pass_cnt++;
    endtask

    task automatic test_masking();
        int_flag_i = 8'h04; global_int_en_i = 1'b0; hold_flag_i = 1'b0;
        inst_addr_i = 32'hC0; csr_mstatus_i = 32'h8;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                global_int_en_i = 1'b1; hold_flag_i = 1'b1;
            end
            @(negedge clk);
            total_cnt++;
            if (hold_flag_o !== 1'b0)
                $display("FAIL mask_hold c%0d: got %b, required 0", c, hold_flag_o);
            else
                pass_cnt++;
            step();
        end
        hold_flag_i = 1'b0;
        wq.push_back({32'h341, 32'hC0});
        wq.push_back({32'h300, 32'h80});
        wq.push_back({32'h342, 32'h8000_000B});
        rq.push_back(32'h100);
        step();
        int_flag_i = '0; global_int_en_i = 1'b0;
        repeat (5) step();
        total_cnt++;
        if (wq.size() != 0 || rq.size() != 0)
            $display("FAIL mask_drain: got %0d writes %0d redirects left, required 0", wq.size(), rq.size());
        else
            pass_cnt++;
    endtask

    task automatic test_mret();
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h84; inst_i = MRET;
        wq.push_back({32'h300, 32'h88});
        rq.push_back(32'h84);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (hold_flag_o !== (c <= 2) || int_assert_o !== (c == 2))
                $display("FAIL mret_timing c%0d: got hold=%b assert=%b, required hold=%b assert=%b",
                         c, hold_flag_o, int_assert_o, (c <= 2), (c == 2));
            else
                pass_cnt++;
            step();
            if (c == 0) inst_i = NOP;
        end
        total_cnt++;
        if (wq.size() != 0 || rq.size() != 0)
            $display("FAIL mret_drain: got %0d writes %0d redirects left, required 0", wq.size(), rq.size());
        else
            pass_cnt++;
    endtask

    task automatic test_priority();
        csr_mtvec_i = 32'h101; csr_mstatus_i = 32'h8; inst_addr_i = 32'hA0;
        inst_i = ECALL; int_flag_i = 8'h01; global_int_en_i = 1'b1;
        wq.push_back({32'h341, 32'hA0});
        wq.push_back({32'h300, 32'h80});
        wq.push_back({32'h342, 32'hB});
        rq.push_back(32'h100);
        step();
        inst_i = NOP; global_int_en_i = 1'b0; inst_addr_i = 32'hA4;
        repeat (6) step();
        total_cnt++;
        if (wq.size() != 0 || rq.size() != 0)
            $display("FAIL prio_sync_first: got %0d writes %0d redirects left, required 0", wq.size(), rq.size());
        else
            pass_cnt++;
        global_int_en_i = 1'b1;
        wq.push_back({32'h341, 32'hA4});
        wq.push_back({32'h300, 32'h80});
        wq.push_back({32'h342, 32'h8000_0007});
        rq.push_back(TIMER_VEC);
        step();
        int_flag_i = '0; global_int_en_i = 1'b0;
        repeat (5) step();
        total_cnt++;
        if (wq.size() != 0 || rq.size() != 0)
            $display("FAIL prio_timer_retry: got %0d writes %0d redirects left, required 0", wq.size(), rq.size());
        else
            pass_cnt++;
        csr_mtvec_i = 32'h100;
    endtask

    task automatic test_reset_mid();
        csr_mstatus_i = 32'h8; inst_addr_i = 32'hE0; inst_i = ECALL;
        wq.push_back({32'h341, 32'hE0});
        wq.push_back({32'h300, 32'h80});
        step();
        inst_i = NOP;
        step();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({we_o, waddr_o, data_o, int_assert_o, int_addr_o, hold_flag_o} !== '0)
            $display("FAIL reset_mid: got we=%b waddr=%h data=%h assert=%b addr=%h hold=%b, required all 0",
                     we_o, waddr_o, data_o, int_assert_o, int_addr_o, hold_flag_o);
        else
            pass_cnt++;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total_cnt++;
            if (hold_flag_o !== 1'b0 || we_o !== 1'b0)
                $display("FAIL reset_mid_idle c%0d: got hold=%b we=%b, required 0 0", c, hold_flag_o, we_o);
            else
                pass_cnt++;
            step();
        end
        total_cnt++;
        if (wq.size() != 0 || rq.size() != 0)
            $display("FAIL reset_mid_drain: got %0d writes %0d redirects left, required 0", wq.size(), rq.size());
        else
            pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_timer();
        test_masking();
        test_mret();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
